obf_seq: RTL and testbench

OBF_SEQ -- requirements
Module: obf_seq

---
 rtl/obf_seq.sv | 195 +++++++++++++++++++
 tb/tb_obf_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obf_seq.sv
// obf_seq -- instruction obfuscation sequencer.
//
// Accepts one original OR1K instruction at a time. It then either passes the
// instruction through unchanged, or replaces it with a sequence of substitute
// instructions. Each substitute step is built from a 16-bit template that an
// external LUT returns for address {igu, sub}.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   obf_en     1 = substitute, 0 = pass through
//   flush      abort the sequence in progress
//   in_valid   original instruction offered
//   in_ready   sequencer idle and able to accept
//   in_insn    original instruction
//   in_igu     substitution-group index of in_insn
//   lut_addr   {igu, sub} address to the substitution LUT
//   lut_out    {type, template[15:0], last}; combinational in lut_addr
//   out_valid  out_insn valid
//   out_ready  consumer accepts out_insn
//   out_insn   emitted instruction
//   out_last   final step of the current sequence
//   out_sub    current step index
//   seq_err    sticky: a sequence ran to MAX_SUB without a last flag
`ifndef OBF_SUB_WIDTH
`define OBF_SUB_WIDTH 4
`endif
`ifndef OBF_IGU_WIDTH
`define OBF_IGU_WIDTH 8
`endif
`ifndef OBF_LUT_ADDR_WIDTH
`define OBF_LUT_ADDR_WIDTH (`OBF_IGU_WIDTH + `OBF_SUB_WIDTH)
`endif
`ifndef OBF_LUT_OUT_WIDTH
`define OBF_LUT_OUT_WIDTH 19
`endif
`ifndef OBF_INSN_TYPE_N
`define OBF_INSN_TYPE_N 2'd0
`endif
`ifndef OBF_INSN_TYPE_I
`define OBF_INSN_TYPE_I 2'd1
`endif
`ifndef OBF_INSN_TYPE_A
`define OBF_INSN_TYPE_A 2'd2
`endif

module obf_seq #(
  parameter logic [5:0] A_OPCODE = 6'h38,
  parameter int         MAX_SUB  = 2**`OBF_SUB_WIDTH-1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           obf_en,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    in_insn,
  input  logic [`OBF_IGU_WIDTH-1:0]      in_igu,
  output logic [`OBF_LUT_ADDR_WIDTH-1:0] lut_addr,
  input  logic [`OBF_LUT_OUT_WIDTH-1:0]  lut_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [31:0]                    out_insn,
  output logic                           out_last,
  output logic [`OBF_SUB_WIDTH-1:0]      out_sub,
  output logic                           seq_err
);

  localparam int SW = `OBF_SUB_WIDTH;
  localparam int IW = `OBF_IGU_WIDTH;
  localparam int LW = `OBF_LUT_OUT_WIDTH;
  localparam logic [SW-1:0] SUB_MAX = SW'(MAX_SUB);
  localparam logic [31:0]   NOP     = 32'h15000000;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     insn_q, insn_d;
  logic [IW-1:0]   igu_q, igu_d;
  logic            en_q, en_d;
  logic [SW-1:0]   sub_q, sub_d;
  logic            err_q, err_d;

  logic [1:0]      lut_type;
  logic [15:0]     tmpl;
  logic            lut_last;
  logic            pass_thru;
  logic            is_sub_step;
  logic            accept_out;

  // Type I: {op, D, A, IMM}; t[9]/t[8] force r0, t[7] selects a
  // sign-extended 6-bit immediate from the template.
  function automatic logic [31:0] asm_i(input logic [15:0] t, input logic [31:0] insn);
    logic [4:0]  d, a;
    logic [15:0] imm;
    d   = t[9] ? 5'd0 : insn[25:21];
    a   = t[8] ? 5'd0 : insn[20:16];
    imm = t[7] ? {{10{t[5]}}, t[5:0]} : insn[15:0];
    return {t[15:10], d, a, imm};
  endfunction

  // Type A: register ALU form; t[7:5] force D/A/B to r0, t[4:3] and t[11:8]
  // fill the function fields.
  function automatic logic [31:0] asm_a(input logic [15:0] t, input logic [31:0] insn);
    logic [4:0] d, a, b;
    d = t[7] ? 5'd0 : insn[25:21];
    a = t[6] ? 5'd0 : insn[20:16];
    b = t[5] ? 5'd0 : insn[15:11];
    return {A_OPCODE, d, a, b, 1'b0, t[4:3], 4'b0000, t[11:8]};
  endfunction

  assign lut_type = lut_out[LW-1 -: 2];
  assign tmpl     = lut_out[16:1];
  assign lut_last = lut_out[0];

  assign lut_addr = {igu_q, sub_q};

  // A type-N result at step 0 means the group has no substitution.
  assign pass_thru   = !en_q || (lut_type == `OBF_INSN_TYPE_N && sub_q == '0);
  assign is_sub_step = (lut_type == `OBF_INSN_TYPE_I) || (lut_type == `OBF_INSN_TYPE_A);

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == EMIT);
  assign out_sub    = sub_q;
  assign seq_err    = err_q;
  assign accept_out = out_valid && out_ready;

  always_comb begin
    out_insn = NOP;
    out_last = 1'b1;
    if (pass_thru) begin
      out_insn = insn_q;
    end else if (lut_type == `OBF_INSN_TYPE_I) begin
      out_insn = asm_i(tmpl, insn_q);
      out_last = lut_last || (sub_q == SUB_MAX);
    end else if (lut_type == `OBF_INSN_TYPE_A) begin
      out_insn = asm_a(tmpl, insn_q);
      out_last = lut_last || (sub_q == SUB_MAX);
    end
  end

  always_comb begin
    state_d = state_q;
    insn_d  = insn_q;
    igu_d   = igu_q;
    en_d    = en_q;
    sub_d   = sub_q;
    err_d   = err_q;
    if (flush) begin
      state_d = IDLE;
      sub_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            insn_d  = in_insn;
            igu_d   = in_igu;
            en_d    = obf_en;
            sub_d   = '0;
            state_d = EMIT;
          end
        end
        EMIT: begin
          if (accept_out) begin
            // Forced termination of a substituted step that never flagged last.
            if (!pass_thru && is_sub_step && sub_q == SUB_MAX && !lut_last)
              err_d = 1'b1;
            if (out_last) state_d = IDLE;
            else          sub_d   = sub_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      insn_q  <= '0;
      igu_q   <= '0;
      en_q    <= 1'b0;
      sub_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      igu_q   <= igu_d;
      en_q    <= en_d;
      sub_q   <= sub_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_obf_seq.sv
`ifndef OBF_SUB_WIDTH
`define OBF_SUB_WIDTH 4
`endif
`ifndef OBF_IGU_WIDTH
`define OBF_IGU_WIDTH 8
`endif
`ifndef OBF_LUT_ADDR_WIDTH
`define OBF_LUT_ADDR_WIDTH (`OBF_IGU_WIDTH + `OBF_SUB_WIDTH)
`endif
`ifndef OBF_LUT_OUT_WIDTH
`define OBF_LUT_OUT_WIDTH 19
`endif

module tb_obf_seq;

  logic        clk = 1'b0;
  logic        rst, obf_en, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_last, seq_err;
  logic [31:0] in_insn, out_insn;
  logic [7:0]  in_igu;
  logic [11:0] lut_addr;
  logic [18:0] lut_out;
  logic [3:0]  out_sub;

  obf_seq dut (
    .clk(clk), .rst(rst), .obf_en(obf_en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_igu(in_igu),
    .lut_addr(lut_addr), .lut_out(lut_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_last(out_last), .out_sub(out_sub), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // LUT model: {type, template, last}; type 0=N, 1=I, 2=A.
  always_comb begin
    lut_out = {2'd0, 16'h0000, 1'b0};
    case (lut_addr[11:4])
      8'd64: case (lut_addr[3:0])
        4'd0: lut_out = {2'd1, 16'h9E80, 1'b0};
        4'd1: lut_out = {2'd2, 16'h0140, 1'b0};
        4'd2: lut_out = {2'd2, 16'h05E0, 1'b1};
        default: lut_out = {2'd0, 16'h0000, 1'b0};
      endcase
      8'd7:  lut_out = {2'd1, 16'h9C00, 1'b0};
      8'd9:  lut_out = (lut_addr[3:0] == 4'd0) ? {2'd1, 16'h9E80, 1'b0} : {2'd0, 16'h0000, 1'b0};
      8'd10: lut_out = {2'd1, 16'h9CBF, 1'b1};
      default: lut_out = {2'd0, 16'h0000, 1'b0};
    endcase
  end

  typedef struct packed {
    logic [31:0] insn;
    logic        last;
    logic [3:0]  sub;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] insn, input logic last, input logic [3:0] sub);
    exp_t e;
    e.insn = insn; e.last = last; e.sub = sub;
    sb.push_back(e);
  endtask

  // Monitor: every accepted output is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", out_insn);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_insn", out_insn, e.insn);
        chk("out_last", {31'b0, out_last}, {31'b0, e.last});
        chk("out_sub", {28'b0, out_sub}, {28'b0, e.sub});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] insn, input logic [7:0] igu, input logic en);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready still 0 after %0d cycles", n);
    end
    in_insn = insn; in_igu = igu; obf_en = en; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (!(in_ready && sb.size() == 0) && cycles < 200) begin
      tick();
      cycles++;
    end
    if (!(in_ready && sb.size() == 0)) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: in_ready=%0d pending=%0d required idle", in_ready, sb.size());
    end
  endtask

  int cyc;

  initial begin
    rst = 1'b1; obf_en = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; in_insn = '0; in_igu = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_seq_err", {31'b0, seq_err}, 32'd0);
    chk("rst_lut_addr", {20'b0, lut_addr}, 32'd0);

    // l.add r3,r4,r5 substituted in three back-to-back steps
    push(32'h9C040000, 1'b0, 4'd0);
    push(32'hE0602801, 1'b0, 4'd1);
    push(32'hE0000005, 1'b1, 4'd2);
    send(32'hE0642800, 8'd64, 1'b1);
    wait_idle(cyc);
    chk("seq3_cycles", cyc, 32'd3);

    // Same sequence, consumer stalls for 4 cycles at step 1
    push(32'h9C040000, 1'b0, 4'd0);
    push(32'hE0602801, 1'b0, 4'd1);
    push(32'hE0000005, 1'b1, 4'd2);
    out_ready = 1'b0;
    send(32'hE0642800, 8'd64, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_insn", out_insn, 32'hE0602801);
      chk("stall_sub", {28'b0, out_sub}, 32'd1);
      chk("stall_addr", {20'b0, lut_addr}, {20'b0, 8'd64, 4'd1});
      tick();
    end
    out_ready = 1'b1;
    wait_idle(cyc);

    // Substitution disabled: pass-through
    push(32'hE0642800, 1'b1, 4'd0);
    send(32'hE0642800, 8'd64, 1'b0);
    wait_idle(cyc);

    // Unmapped group: pass-through, no error
    push(32'h9C230010, 1'b1, 4'd0);
    send(32'h9C230010, 8'd5, 1'b1);
    wait_idle(cyc);
    chk("unmapped_seq_err", {31'b0, seq_err}, 32'd0);

    // Type N at step 1 becomes an l.nop final step
    push(32'h9C040000, 1'b0, 4'd0);
    push(32'h15000000, 1'b1, 4'd1);
    send(32'hE0642800, 8'd9, 1'b1);
    wait_idle(cyc);

    // Sign-extended 6-bit immediate
    push(32'h9C64FFFF, 1'b1, 4'd0);
    send(32'hE0642800, 8'd10, 1'b1);
    wait_idle(cyc);

    // Flush at step 1, then a fresh sequence from step 0
    push(32'h9C040000, 1'b0, 4'd0);
    out_ready = 1'b0;
    send(32'hE0642800, 8'd64, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pre_flush_sub", {28'b0, out_sub}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    push(32'h9C040000, 1'b0, 4'd0);
    push(32'hE0602801, 1'b0, 4'd1);
    push(32'hE0000005, 1'b1, 4'd2);
    send(32'hE0642800, 8'd64, 1'b1);
    wait_idle(cyc);

    // Flush beats in_valid in IDLE
    in_insn = 32'hE0642800; in_igu = 8'd64; obf_en = 1'b1;
    flush = 1'b1; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_prio_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_prio_ready", {31'b0, in_ready}, 32'd1);

    // LUT never sets last: forced termination at step 15 and sticky error
    for (int s = 0; s < 16; s++)
      push(32'h9C642800, (s == 15), 4'(s));
    send(32'hE0642800, 8'd7, 1'b1);
    wait_idle(cyc);
    chk("maxsub_seq_err", {31'b0, seq_err}, 32'd1);
    push(32'h12345678, 1'b1, 4'd0);
    send(32'h12345678, 8'd5, 1'b0);
    wait_idle(cyc);
    chk("seq_err_sticky", {31'b0, seq_err}, 32'd1);

    // Reset in the middle of a sequence
    out_ready = 1'b0;
    send(32'hE0642800, 8'd64, 1'b1);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_seq_err", {31'b0, seq_err}, 32'd0);
    chk("midrst_lut_addr", {20'b0, lut_addr}, 32'd0);
    out_ready = 1'b1;
    tick();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
